// File: rtl/exec_muldiv_pkg.sv
// exec_muldiv_pkg: shared op codes, FSM states and helpers for the EX-stage multiply/divide unit
// Contents: OP_* op encodings, state_t (ST_IDLE/ST_BUSY), absVal() two's-complement magnitude
package exec_muldiv_pkg;
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam int MAX_W = 64;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    // Callers sign- or zero-extend into MAX_W bits first, so the MSB is the operand sign.
    // The low bits of the result are the correct unsigned magnitude, including for the most negative value.
    function automatic logic [MAX_W-1:0] absVal(input logic [MAX_W-1:0] x);
        return x[MAX_W-1] ? -x : x;
    endfunction
endpackage

// File: rtl/exec_muldiv_unit_if.sv
// exec_muldiv_unit_if: EX-stage request/response bundle between the pipeline and the mul/div unit
// master: drives ValidIn, OpIn, FlushIn, OperandAIn, OperandBIn
//         and receives ResultOut, StallOut, BusyOut, DivZeroOut, HiOut, LoOut
// slave:  the opposite directions
interface exec_muldiv_unit_if #(parameter int DATA_W = 32);
    logic              ValidIn;
    logic              FlushIn;
    logic [3:0]        OpIn;
    logic [DATA_W-1:0] OperandAIn;
    logic [DATA_W-1:0] OperandBIn;
    logic [DATA_W-1:0] ResultOut;
    logic [DATA_W-1:0] HiOut;
    logic [DATA_W-1:0] LoOut;
    logic              StallOut;
    logic              BusyOut;
    logic              DivZeroOut;

    modport master (output ValidIn, OpIn, FlushIn, OperandAIn, OperandBIn,
                    input  ResultOut, StallOut, BusyOut, DivZeroOut, HiOut, LoOut);
    modport slave  (input  ValidIn, OpIn, FlushIn, OperandAIn, OperandBIn,
                    output ResultOut, StallOut, BusyOut, DivZeroOut, HiOut, LoOut);
endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// Ports: Clk, Rst (sync, active high), Start (load operands), Abort (drop the op),
//        IsDivIn (divide when high), OpAIn/OpBIn (unsigned magnitudes),
//        DoneOut (high in the final iteration cycle), HiOut/LoOut (result valid while DoneOut)
// Optional macro MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module muldiv_iter_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    input  logic              IsDivIn,
    input  logic [DATA_W-1:0] OpAIn,
    input  logic [DATA_W-1:0] OpBIn,
    output logic              DoneOut,
    output logic [DATA_W-1:0] HiOut,
    output logic [DATA_W-1:0] LoOut
);
    logic              active, isDiv, doneNow;
    logic [CNT_W-1:0]  count;
    // accReg: product high half / partial remainder; qReg: multiplier / dividend-then-quotient
    logic [DATA_W-1:0] accReg, qReg, bReg, accNext, qNext;
    logic [DATA_W:0]   mulSum, divShift, divDiff;
`ifdef MULDIV_EARLY_OUT_EN
    logic [DATA_W-1:0] restMask;
`endif

    always_comb begin
        mulSum   = {1'b0, accReg} + (qReg[0] ? {1'b0, bReg} : '0);
        divShift = {accReg, qReg[DATA_W-1]};
        divDiff  = divShift - {1'b0, bReg};
        // Borrow out of the trial subtract means the divisor did not fit: restore.
        accNext  = isDiv ? (divDiff[DATA_W] ? divShift[DATA_W-1:0] : divDiff[DATA_W-1:0]) : mulSum[DATA_W:1];
        qNext    = isDiv ? {qReg[DATA_W-2:0], ~divDiff[DATA_W]} : {mulSum[0], qReg[DATA_W-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
        // Unprocessed multiplier bits sit in the low count-1 bits of qNext.
        restMask = (DATA_W'(1) << (count - CNT_W'(1))) - DATA_W'(1);
        doneNow  = count == CNT_W'(1) || (!isDiv && (qNext & restMask) == '0);
        // Skipped iterations would only shift right, so apply them in one go.
        {HiOut, LoOut} = {accNext, qNext} >> (count - CNT_W'(1));
`else
        doneNow  = count == CNT_W'(1);
        {HiOut, LoOut} = {accNext, qNext};
`endif
        DoneOut  = active && doneNow;
    end

    always_ff @(posedge Clk) begin
        if (Rst || Abort) begin
            active <= 1'b0;
            count  <= '0;
        end else if (Start) begin
            active <= 1'b1;
            isDiv  <= IsDivIn;
            count  <= CNT_W'(DATA_W);
            accReg <= '0;
            qReg   <= IsDivIn ? OpAIn : OpBIn;
            bReg   <= IsDivIn ? OpBIn : OpAIn;
        end else if (active) begin
            accReg <= accNext;
            qReg   <= qNext;
            count  <= count - CNT_W'(1);
            if (DoneOut) active <= 1'b0;
        end
    end
endmodule

// File: rtl/exec_muldiv_unit.sv
// exec_muldiv_unit: EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO and MFHI/MFLO/MTHI/MTLO
// Ports: Clk, Rst (sync, active high), bus (exec_muldiv_unit_if.slave: op request in,
//        ResultOut/StallOut/BusyOut/DivZeroOut/HiOut/LoOut out)
// Optional macro MULDIV_EARLY_OUT_EN (passed through to muldiv_iter_core): early multiply termination.
module exec_muldiv_unit
    import exec_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic                 Clk,
    input logic                 Rst,
    exec_muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    state_t            state, stateNext;
    logic [DATA_W-1:0] hiReg, loReg, hiNext, loNext, coreHi, coreLo, absA, absB;
    logic [MAX_W-1:0]  extA, extB;
    logic              negRes, negRem, isDivReg, isSigned, isDiv, isMulDiv, isHiLoOp;
    logic              idleOp, issue, divZero, start, coreDone;

    always_comb begin
        isMulDiv = bus.OpIn inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        isHiLoOp = isMulDiv || bus.OpIn inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
        isSigned = bus.OpIn inside {OP_MULT, OP_DIV};
        isDiv    = bus.OpIn inside {OP_DIV, OP_DIVU};
        idleOp   = state == ST_IDLE && bus.ValidIn && !bus.FlushIn;
        issue    = idleOp && isMulDiv;
        divZero  = issue && isDiv && bus.OperandBIn == '0;
        start    = issue && !divZero;
        extA     = isSigned ? MAX_W'(signed'(bus.OperandAIn)) : MAX_W'(bus.OperandAIn);
        extB     = isSigned ? MAX_W'(signed'(bus.OperandBIn)) : MAX_W'(bus.OperandBIn);
        absA     = DATA_W'(absVal(extA));
        absB     = DATA_W'(absVal(extB));
        stateNext = state;
        if (state == ST_IDLE && start) stateNext = ST_BUSY;
        if (state == ST_BUSY && (coreDone || bus.FlushIn)) stateNext = ST_IDLE;
        hiNext = hiReg;
        loNext = loReg;
        // Completion outranks a same-cycle flush; BUSY never overlaps an IDLE-side write.
        if (coreDone && isDivReg) begin
            loNext = negRes ? -coreLo : coreLo;
            hiNext = negRem ? -coreHi : coreHi;
        end else if (coreDone) begin
            {hiNext, loNext} = negRes ? -{coreHi, coreLo} : {coreHi, coreLo};
        end else if (divZero) begin
            hiNext = bus.OperandAIn;
            loNext = '1;
        end else if (idleOp && bus.OpIn == OP_MTHI) begin
            hiNext = bus.OperandAIn;
        end else if (idleOp && bus.OpIn == OP_MTLO) begin
            loNext = bus.OperandAIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            hiReg    <= '0;
            loReg    <= '0;
            negRes   <= 1'b0;
            negRem   <= 1'b0;
            isDivReg <= 1'b0;
        end else begin
            state <= stateNext;
            hiReg <= hiNext;
            loReg <= loNext;
            if (start) begin
                negRes   <= isSigned && (bus.OperandAIn[DATA_W-1] ^ bus.OperandBIn[DATA_W-1]);
                negRem   <= isSigned && bus.OperandAIn[DATA_W-1];
                isDivReg <= isDiv;
            end
        end
    end

    muldiv_iter_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) core (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (start),
        .Abort   (bus.FlushIn),
        .IsDivIn (isDiv),
        .OpAIn   (absA),
        .OpBIn   (absB),
        .DoneOut (coreDone),
        .HiOut   (coreHi),
        .LoOut   (coreLo)
    );

    assign bus.StallOut   = state == ST_BUSY && bus.ValidIn && isHiLoOp && !bus.FlushIn;
    assign bus.BusyOut    = state == ST_BUSY;
    assign bus.DivZeroOut = divZero;
    assign bus.HiOut      = hiReg;
    assign bus.LoOut      = loReg;
    assign bus.ResultOut  = (state == ST_IDLE && bus.ValidIn && bus.OpIn == OP_MFHI) ? hiReg :
                            (state == ST_IDLE && bus.ValidIn && bus.OpIn == OP_MFLO) ? loReg : '0;
endmodule

// File: doc/exec_muldiv_unit.md
Name: exec_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers. It sits in the EX stage beside the single-cycle ALU datapath.
- Takes already-forwarded operands A/B with an op code. It runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and services MFHI/MFLO/MTHI/MTLO.
- Raises an interlock stall to the hazard unit only when a HI/LO consumer arrives while an operation is in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width; must be even and >= 8.
- CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- ValidIn  input  1  op in ID/EX is real; low acts as NOP.
- OpIn  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NOP.
- FlushIn  input  1  aborts an in-flight op and any issuing op.
- OperandAIn  input  DATA_W  rs after forwarding.
- OperandBIn  input  DATA_W  rt after forwarding.
- ResultOut  output  DATA_W  MFHI/MFLO read data, combinational; 0 otherwise.
- StallOut  output  1  freeze PC, IF/ID, ID/EX; bubble EX/MEM.
- BusyOut  output  1  state is BUSY.
- DivZeroOut  output  1  one-cycle pulse when DIV/DIVU with B==0 issues.
- HiOut, LoOut  output  DATA_W  architectural HI/LO, for debug and trace.

Behaviour:
- Reset: state IDLE, HI=LO=0, counter=0. All outputs 0. Reset mid-operation discards it.
- States:
  - IDLE: accepts any op.
  - BUSY: iterating; counter counts down from DATA_W.
- Issue (IDLE, ValidIn, OpIn in 1-4, !FlushIn):
  - Latch |A| and |B| for signed ops, or raw A and B for unsigned ops.
  - Latch the result-sign flags.
  - Set counter=DATA_W and go to BUSY.
- Iterations:
  - Multiply is shift-add into a 2*DATA_W product register.
  - Divide is restoring: shift remainder, trial subtract, set quotient bit.
- Latency: op issued in cycle c occupies BUSY in cycles c+1..c+DATA_W.
  - The final iteration plus sign correction is written to HI/LO at the end of cycle c+DATA_W.
  - State is IDLE in cycle c+DATA_W+1.
- Result mapping:
  - Multiply: HI = upper product, LO = lower product.
  - Divide: LO = quotient, HI = remainder.
- Sign correction:
  - Quotient negated if signs of A and B differ.
  - Remainder takes the sign of the dividend.
  - Product negated if signs differ.
- Boundary: DIV with A=-2^(DATA_W-1), B=-1 gives LO=-2^(DATA_W-1), HI=0. No trap.
- Divide by zero:
  - No BUSY. HI=A, LO=all ones, written at the issue edge.
  - DivZeroOut=1 in the issue cycle.
- StallOut = BUSY & ValidIn & OpIn in 1-8. Other instructions proceed while BUSY.
  - When StallOut is high, the unit ignores the op; it is re-presented after the stall.
- MFHI/MFLO in IDLE: ResultOut = HI/LO that same cycle.
- MTHI/MTLO in IDLE: HI/LO = OperandAIn at the clock edge.
- FlushIn:
  - BUSY goes to IDLE next edge with HI/LO unchanged.
  - In IDLE, suppresses issue and MT writes.
  - StallOut is forced 0 in that cycle.
- Flush and completion in the same cycle: completion wins, and HI/LO are written.
- Reset has priority over flush, and flush over issue.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: multiply terminates early once the remaining multiplier bits are all zero.
  - The product is aligned with a final shift by the remaining count, then HI/LO are written.
  - Latency for MULT/MULTU is 1 + index of the highest set bit of |B|, minimum 1 BUSY cycle. Divide is unchanged.
- Undefined: fixed DATA_W BUSY cycles for all ops.

Decomposition:
- Package exec_muldiv_pkg:
  - op encoding localparams (OP_NOP..OP_MTLO).
  - state encoding (ST_IDLE, ST_BUSY).
  - helper function for two's-complement absolute value.
- Sub-module muldiv_iter_core holds the iterative datapath and counter:
  - product/remainder register, quotient/multiplier register.
  - start/abort inputs; done pulse output.
- Top level owns the FSM, stall/flush logic, HI/LO and sign correction.

Test Plan (DATA_W=32):
- MULT A=-3, B=7 -> StallOut 0 during the op; after 32 BUSY cycles HI=FFFFFFFF, LO=FFFFFFEB.
- DIVU A=100, B=7, then DIV A=-7, B=2 -> LO=0000000E, HI=00000002; then LO=FFFFFFFD, HI=FFFFFFFF.
- MULTU followed immediately by MFLO -> StallOut high exactly 32 cycles; MFLO ResultOut is the new LO in the cycle after StallOut falls. An intervening ADD is not stalled.
- DIV A=5, B=0 -> DivZeroOut pulses 1 cycle, BusyOut never high, HI=5, LO=FFFFFFFF.
- DIV issued, FlushIn at BUSY cycle 10 -> IDLE next cycle, HI/LO keep prior values. Repeat with Rst at cycle 10 -> HI=LO=0, all outputs 0.
- MTHI 12345678 then MFHI, and DIV A=80000000, B=FFFFFFFF -> ResultOut=12345678; then LO=80000000, HI=0.
